// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared game-state encodings and default playfield geometry
package pong_pkg;

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } game_state_t;

    localparam int DEF_H_MAX      = 640;
    localparam int DEF_V_MAX      = 480;
    localparam int DEF_BALL_SIZE  = 8;
    localparam int DEF_BALL_STEP  = 4;
    localparam int DEF_PAD_HALF   = 50;
    localparam int DEF_PAD1_X     = 20;
    localparam int DEF_PAD2_X     = 610;
    localparam int DEF_PAD_W      = 10;
    localparam int DEF_SERVE_X    = 320;
    localparam int DEF_SERVE_Y    = 240;
    localparam int DEF_SERVE_HOLD = 30;
    localparam int DEF_WIN_SCORE  = 10;

    // Zero-extend a 10-bit screen coordinate into the 11-bit signed math domain.
    function automatic logic signed [10:0] to_s11(input logic [9:0] v);
        return signed'({1'b0, v});
    endfunction

endpackage

// File: rtl/pong_paddle_hit.sv
// rtl/pong_paddle_hit.sv - vertical overlap test between the ball and one paddle
module pong_paddle_hit
    import pong_pkg::*;
#(
    parameter int BALL_SIZE = DEF_BALL_SIZE,
    parameter int PAD_HALF  = DEF_PAD_HALF
) (
    input  logic [9:0] i_ball_y,
    input  logic [9:0] i_pad_y,
    output logic       o_overlap
);

    localparam logic signed [10:0] C_SIZE = 11'(BALL_SIZE);
    localparam logic signed [10:0] C_HALF = 11'(PAD_HALF);

    logic signed [10:0] w_by;
    logic signed [10:0] w_py;

    assign w_by      = to_s11(i_ball_y);
    assign w_py      = to_s11(i_pad_y);
    assign o_overlap = (w_by + C_SIZE >= w_py - C_HALF) && (w_by <= w_py + C_HALF);

endmodule

// File: rtl/pong_ball_engine.sv
// rtl/pong_ball_engine.sv - per-tick ball motion, bounces, scoring and game FSM
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int H_MAX      = DEF_H_MAX,
    parameter int V_MAX      = DEF_V_MAX,
    parameter int BALL_SIZE  = DEF_BALL_SIZE,
    parameter int BALL_STEP  = DEF_BALL_STEP,
    parameter int PAD_HALF   = DEF_PAD_HALF,
    parameter int PAD1_X     = DEF_PAD1_X,
    parameter int PAD2_X     = DEF_PAD2_X,
    parameter int PAD_W      = DEF_PAD_W,
    parameter int SERVE_X    = DEF_SERVE_X,
    parameter int SERVE_Y    = DEF_SERVE_Y,
    parameter int SERVE_HOLD = DEF_SERVE_HOLD,
    parameter int WIN_SCORE  = DEF_WIN_SCORE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] pad1_y,
    input  logic [9:0] pad2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] state,
    output logic       scored
);

    localparam int HOLD_W = $clog2(SERVE_HOLD + 1);

    localparam logic signed [10:0] C_STEP   = 11'(BALL_STEP);
    localparam logic signed [10:0] C_SIZE   = 11'(BALL_SIZE);
    localparam logic signed [10:0] C_X_MISS = 11'(H_MAX - BALL_SIZE);
    localparam logic signed [10:0] C_Y_BOT  = 11'(V_MAX - BALL_SIZE);
    localparam logic signed [10:0] C_PAD2_X = 11'(PAD2_X);
    localparam logic signed [10:0] C_PAD1_R = 11'(PAD1_X + PAD_W);
    localparam logic signed [10:0] C_ZERO   = '0;

    game_state_t       r_state, w_state_n;
    logic [9:0]        r_x, r_y, w_x_n, w_y_n;
    logic              r_dy, w_dy_n;
    logic [HOLD_W-1:0] r_hold, w_hold_n;
    logic [3:0]        r_p1, r_p2, w_p1_n, w_p2_n, w_p1_inc, w_p2_inc;
    logic              r_scored, w_scored_n;

    logic signed [10:0] w_x, w_y, w_nx, w_ny;
    logic               w_right, w_move, w_ov1, w_ov2;
    logic               w_wall_hi, w_wall_lo, w_dy_wall;
    logic [9:0]         w_y_wall;
    logic               w_hit1, w_hit2, w_miss1, w_miss2;

    pong_paddle_hit #(.BALL_SIZE(BALL_SIZE), .PAD_HALF(PAD_HALF)) u_hit1 (
        .i_ball_y (r_y),
        .i_pad_y  (pad1_y),
        .o_overlap(w_ov1)
    );

    pong_paddle_hit #(.BALL_SIZE(BALL_SIZE), .PAD_HALF(PAD_HALF)) u_hit2 (
        .i_ball_y (r_y),
        .i_pad_y  (pad2_y),
        .o_overlap(w_ov2)
    );

    // QI serves rightward, so only QGAME_2 travels left.
    assign w_right = (r_state != QGAME_2);
    assign w_x     = to_s11(r_x);
    assign w_y     = to_s11(r_y);
    assign w_nx    = w_right ? w_x + C_STEP : w_x - C_STEP;
    assign w_ny    = r_dy ? w_y + C_STEP : w_y - C_STEP;

    assign w_wall_hi = r_dy && (w_ny >= C_Y_BOT);
    assign w_wall_lo = !r_dy && (w_ny <= C_ZERO);
    assign w_y_wall  = w_wall_hi ? 10'(V_MAX - BALL_SIZE) : (w_wall_lo ? 10'd0 : w_ny[9:0]);
    assign w_dy_wall = r_dy ^ (w_wall_hi | w_wall_lo);

    assign w_hit2  = (w_nx + C_SIZE >= C_PAD2_X) && (w_x + C_SIZE <= C_PAD2_X) && w_ov2;
    assign w_miss2 = (w_nx >= C_X_MISS);
    assign w_hit1  = (w_nx <= C_PAD1_R) && (w_x >= C_PAD1_R) && w_ov1;
    assign w_miss1 = (w_nx <= C_ZERO);

    assign w_p1_inc = (r_p1 != 4'(WIN_SCORE)) ? r_p1 + 4'd1 : r_p1;
    assign w_p2_inc = (r_p2 != 4'(WIN_SCORE)) ? r_p2 + 4'd1 : r_p2;

    always_comb begin
        w_state_n  = r_state;
        w_x_n      = r_x;
        w_y_n      = r_y;
        w_dy_n     = r_dy;
        w_hold_n   = r_hold;
        w_p1_n     = r_p1;
        w_p2_n     = r_p2;
        w_scored_n = 1'b0;
        w_move     = 1'b0;

        if (tick) begin
            case (r_state)
                QI: begin
                    if (start) begin
                        w_state_n = QGAME_1;
                        w_move    = 1'b1;
                    end
                end
                QGAME_1, QGAME_2: begin
                    if (r_hold != '0) w_hold_n = r_hold - HOLD_W'(1);
                    else              w_move   = 1'b1;
                end
                QDONE: begin
                    if (!start) begin
                        w_state_n = QI;
                        w_p1_n    = '0;
                        w_p2_n    = '0;
                        w_hold_n  = '0;
                    end
                end
                default: w_state_n = QI;
            endcase
        end

        if (w_move) begin
            w_y_n  = w_y_wall;
            w_dy_n = w_dy_wall;
            if (w_right ? w_hit2 : w_hit1) begin
                w_x_n     = w_right ? 10'(PAD2_X - BALL_SIZE) : 10'(PAD1_X + PAD_W);
                w_state_n = w_right ? QGAME_2 : QGAME_1;
            end else if (w_right ? w_miss2 : w_miss1) begin
                // A miss overrides any wall bounce in the same tick; dy survives the re-serve.
                w_scored_n = 1'b1;
                w_x_n      = 10'(SERVE_X);
                w_y_n      = 10'(SERVE_Y);
                w_dy_n     = r_dy;
                w_hold_n   = HOLD_W'(SERVE_HOLD);
                if (w_right) w_p1_n = w_p1_inc;
                else         w_p2_n = w_p2_inc;
                if ((w_right ? w_p1_inc : w_p2_inc) == 4'(WIN_SCORE)) w_state_n = QDONE;
            end else begin
                w_x_n = w_nx[9:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= QI;
            r_x      <= 10'(SERVE_X);
            r_y      <= 10'(SERVE_Y);
            r_dy     <= 1'b1;
            r_hold   <= '0;
            r_p1     <= '0;
            r_p2     <= '0;
            r_scored <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_x      <= w_x_n;
            r_y      <= w_y_n;
            r_dy     <= w_dy_n;
            r_hold   <= w_hold_n;
            r_p1     <= w_p1_n;
            r_p2     <= w_p2_n;
            r_scored <= w_scored_n;
        end
    end

    assign ball_x   = r_x;
    assign ball_y   = r_y;
    assign p1_score = r_p1;
    assign p2_score = r_p2;
    assign state    = r_state;
    assign scored   = r_scored;

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb/tb_pong_ball_engine.sv - self-checking bench for pong_ball_engine against a behavioural game model
module tb_pong_ball_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] pad1_y = '0;
    logic [9:0] pad2_y = '0;
    logic [9:0] ball_x, ball_y;
    logic [3:0] p1_score, p2_score;
    logic [1:0] state;
    logic       scored;

    int passed = 0;
    int total  = 0;

    // Game model: plain integers, state 0=idle 1=rightward 2=leftward 3=done, dy +1 down / -1 up.
    int m_state, m_x, m_y, m_dy, m_hold, m_p1, m_p2, m_scored;

    pong_ball_engine dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .start   (start),
        .pad1_y  (pad1_y),
        .pad2_y  (pad2_y),
        .ball_x  (ball_x),
        .ball_y  (ball_y),
        .p1_score(p1_score),
        .p2_score(p2_score),
        .state   (state),
        .scored  (scored)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    wire [30:0] dut_vec = {ball_x, ball_y, p1_score, p2_score, state, scored};

    function automatic logic [30:0] model_vec();
        return {10'(m_x), 10'(m_y), 4'(m_p1), 4'(m_p2), 2'(m_state), 1'(m_scored)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_x = 320; m_y = 240; m_dy = 1;
        m_hold = 0; m_p1 = 0; m_p2 = 0; m_scored = 0;
    endtask

    task automatic model_point(input bit to_p1);
        m_scored = 1; m_x = 320; m_y = 240; m_hold = 30;
        if (to_p1) begin
            if (m_p1 < 10) m_p1++;
            if (m_p1 == 10) m_state = 3;
        end else begin
            if (m_p2 < 10) m_p2++;
            if (m_p2 == 10) m_state = 3;
        end
    endtask

    task automatic model_tick(input int p1y, input int p2y, input bit st);
        int nx, ny, ndy, pad;
        bit ov, go;
        m_scored = 0;
        go = 0;
        if (m_state == 0) begin
            if (st) begin m_state = 1; go = 1; end
        end else if (m_state == 3) begin
            if (!st) begin m_state = 0; m_p1 = 0; m_p2 = 0; m_hold = 0; end
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            go = 1;
        end
        if (go) begin
            nx  = (m_state == 1) ? m_x + 4 : m_x - 4;
            ny  = m_y + 4 * m_dy;
            ndy = m_dy;
            if (m_dy > 0 && ny >= 472) begin ny = 472; ndy = -1; end
            if (m_dy < 0 && ny <= 0)   begin ny = 0;   ndy = 1;  end
            pad = (m_state == 1) ? p2y : p1y;
            ov  = (m_y + 8 >= pad - 50) && (m_y <= pad + 50);
            if (m_state == 1 && nx + 8 >= 610 && m_x + 8 <= 610 && ov) begin
                m_x = 602; m_y = ny; m_dy = ndy; m_state = 2;
            end else if (m_state == 2 && nx <= 30 && m_x >= 30 && ov) begin
                m_x = 30; m_y = ny; m_dy = ndy; m_state = 1;
            end else if (m_state == 1 && nx >= 632) begin
                model_point(1);
            end else if (m_state == 2 && nx <= 0) begin
                model_point(0);
            end else begin
                m_x = nx; m_y = ny; m_dy = ndy;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; tick = 1'b0; start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_tick(input int p1y, input int p2y, input bit st);
        @(negedge clk);
        pad1_y = 10'(p1y); pad2_y = 10'(p2y); start = st; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        model_tick(p1y, p2y, st);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (state !== 2'b00) $display("FAIL reset_state got %0d want 0", state); else passed++;
        total++; if ({ball_x, ball_y} !== {10'd320, 10'd240})
            $display("FAIL reset_ball got (%0d,%0d) want (320,240)", ball_x, ball_y); else passed++;
        total++; if ({p1_score, p2_score, scored} !== 9'd0)
            $display("FAIL reset_scores got %0d/%0d scored %0d want 0/0 0", p1_score, p2_score, scored); else passed++;
    endtask

    task automatic test_start_idle();
        apply_reset();
        do_tick(500, 500, 1);
        total++; if ({state, ball_x, ball_y} !== {2'b01, 10'd324, 10'd244})
            $display("FAIL start_tick got st %0d (%0d,%0d) want 1 (324,244)", state, ball_x, ball_y); else passed++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = i[0]; pad2_y = 10'($urandom_range(0, 900));
        end
        total++; if ({state, ball_x, ball_y} !== {2'b01, 10'd324, 10'd244})
            $display("FAIL no_tick_hold got st %0d (%0d,%0d) want 1 (324,244)", state, ball_x, ball_y); else passed++;
    endtask

    task automatic test_wall();
        apply_reset();
        for (int i = 0; i < 58; i++) do_tick(500, m_y, 1);
        total++; if (ball_y !== 10'd472) $display("FAIL wall_clamp got %0d want 472", ball_y); else passed++;
        do_tick(500, m_y, 1);
        total++; if (ball_y !== 10'd468) $display("FAIL wall_flip got %0d want 468", ball_y); else passed++;
    endtask

    task automatic test_paddle_hit();
        apply_reset();
        for (int i = 0; i < 71; i++) do_tick(500, m_y, 1);
        total++; if ({ball_x, state} !== {10'd602, 2'b10})
            $display("FAIL p2_hit got x %0d st %0d want x 602 st 2", ball_x, state); else passed++;
        total++; if ({p1_score, p2_score} !== 8'd0)
            $display("FAIL p2_hit_scores got %0d/%0d want 0/0", p1_score, p2_score); else passed++;
        total++; if (dut_vec !== model_vec())
            $display("FAIL p2_hit_model got %h want %h", dut_vec, model_vec()); else passed++;
    endtask

    task automatic test_miss_and_hold();
        int frozen_bad;
        apply_reset();
        for (int i = 0; i < 78; i++) do_tick(500, 0, 1);
        total++; if ({p1_score, scored, state} !== {4'd1, 1'b1, 2'b01})
            $display("FAIL miss_score got p1 %0d scored %0d st %0d want 1 1 1", p1_score, scored, state); else passed++;
        total++; if ({ball_x, ball_y} !== {10'd320, 10'd240})
            $display("FAIL miss_serve got (%0d,%0d) want (320,240)", ball_x, ball_y); else passed++;
        @(negedge clk);
        total++; if (scored !== 1'b0) $display("FAIL scored_pulse got %0d want 0", scored); else passed++;
        frozen_bad = 0;
        for (int i = 0; i < 30; i++) begin
            do_tick(500, 0, 1);
            if ({ball_x, ball_y} !== {10'd320, 10'd240}) frozen_bad++;
        end
        total++; if (frozen_bad != 0) $display("FAIL serve_hold moved on %0d of 30 ticks want 0", frozen_bad); else passed++;
        do_tick(500, 0, 1);
        total++; if ({ball_x, ball_y} !== {10'd324, 10'd236})
            $display("FAIL serve_release got (%0d,%0d) want (324,236)", ball_x, ball_y); else passed++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 90; i++) do_tick(500, 0, 1);
        total++; if (dut_vec !== model_vec())
            $display("FAIL pre_reset_model got %h want %h", dut_vec, model_vec()); else passed++;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (dut_vec !== {10'd320, 10'd240, 4'd0, 4'd0, 2'b00, 1'b0})
            $display("FAIL async_reset got %h want %h", dut_vec, {10'd320, 10'd240, 11'd0}); else passed++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        do_tick(500, 500, 1);
        total++; if ({state, ball_x, ball_y} !== {2'b01, 10'd324, 10'd244})
            $display("FAIL post_reset_tick got st %0d (%0d,%0d) want 1 (324,244)", state, ball_x, ball_y); else passed++;
    endtask

    task automatic test_win();
        apply_reset();
        for (int i = 0; i < 3000 && m_state != 3; i++) do_tick(500, 1023, 1);
        total++; if (m_state != 3) $display("FAIL win_timeout model state %0d want 3", m_state); else passed++;
        total++; if ({state, p1_score, p2_score} !== {2'b11, 4'd10, 4'd0})
            $display("FAIL win_state got st %0d %0d/%0d want 3 10/0", state, p1_score, p2_score); else passed++;
        do_tick(500, 1023, 1);
        total++; if ({state, p1_score, ball_x, ball_y} !== {2'b11, 4'd10, 10'd320, 10'd240})
            $display("FAIL done_frozen got st %0d p1 %0d (%0d,%0d) want 3 10 (320,240)", state, p1_score, ball_x, ball_y); else passed++;
        do_tick(500, 1023, 0);
        total++; if ({state, p1_score, p2_score} !== {2'b00, 4'd0, 4'd0})
            $display("FAIL done_exit got st %0d %0d/%0d want 0 0/0", state, p1_score, p2_score); else passed++;
    endtask

    task automatic test_random();
        int bad, gap, p1, p2;
        bit st;
        apply_reset();
        bad = 0;
        for (int i = 0; i < 800; i++) begin
            p1 = m_y + int'($urandom_range(0, 160)) - 80;
            p2 = m_y + int'($urandom_range(0, 160)) - 80;
            if (p1 < 0) p1 = 0; if (p1 > 900) p1 = 900;
            if (p2 < 0) p2 = 0; if (p2 > 900) p2 = 900;
            st = ($urandom_range(0, 15) != 0);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                m_scored = 0;
                total++;
                if (dut_vec !== model_vec()) begin
                    $display("FAIL random_idle iter %0d got %h want %h", i, dut_vec, model_vec());
                    bad++;
                end else passed++;
            end
            do_tick(p1, p2, st);
            total++;
            if (dut_vec !== model_vec()) begin
                if (bad < 10) $display("FAIL random_tick iter %0d got %h want %h", i, dut_vec, model_vec());
                bad++;
            end else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_start_idle();
        test_wall();
        test_paddle_hit();
        test_miss_and_hold();
        test_async_reset();
        test_win();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
